// File: rtl/mem_slave.sv
// mem_slave: on-chip memory bus slave with wait states, byte-enabled writes,
// optional write protection and an error response for out-of-range addresses.
module mem_slave #(
    parameter int    DATA_W      = 32,
    parameter int    ADDR_W      = 30,
    parameter int    DEPTH_LOG2  = 11,
    parameter int    WAIT_STATES = 0,
    parameter int    WRITABLE    = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  CS_,
    input  logic                  As_,
    input  logic                  RW,
    input  logic [ADDR_W-1:0]     Addr,
    input  logic [DATA_W/8-1:0]   ByteEn_,
    input  logic [DATA_W-1:0]     WrData,
    output logic [DATA_W-1:0]     RdData,
    output logic                  Rdy_,
    output logic                  Err_
);
    localparam int NB = DATA_W / 8;
    localparam logic [3:0] WS_M1 = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_rw;
    logic [ADDR_W-1:0]     r_addr;
    logic [NB-1:0]         r_be_n;
    logic [DATA_W-1:0]     r_wd;
    logic [DATA_W-1:0]     r_rd;
    logic                  r_rdy_n;
    logic                  r_err_n;
    logic [DATA_W-1:0]     r_mem [2**DEPTH_LOG2];

    logic                  w_req;
    logic                  w_go;
    logic                  w_rw;
    logic [ADDR_W-1:0]     w_addr;
    logic [NB-1:0]         w_be_n;
    logic [DATA_W-1:0]     w_wd;
    logic                  w_oor;
    logic                  w_err;
    logic [DEPTH_LOG2-1:0] w_idx;

    assign w_req  = !CS_ && !As_ && (r_state == S_IDLE || r_state == S_ACK);
    // With no wait states the access commits on the strobe edge itself,
    // so the live bus is used instead of the captured copy.
    assign w_go   = (WAIT_STATES == 0) ? w_req  : (r_state == S_WAIT && r_cnt == 4'd0);
    assign w_rw   = (WAIT_STATES == 0) ? RW      : r_rw;
    assign w_addr = (WAIT_STATES == 0) ? Addr    : r_addr;
    assign w_be_n = (WAIT_STATES == 0) ? ByteEn_ : r_be_n;
    assign w_wd   = (WAIT_STATES == 0) ? WrData  : r_wd;
    assign w_oor  = |w_addr[ADDR_W-1:DEPTH_LOG2];
    assign w_err  = w_oor || (!w_rw && WRITABLE == 0);
    assign w_idx  = w_addr[DEPTH_LOG2-1:0];

    always_ff @(posedge clk) begin
        if (w_go && !w_rw && !w_err)
            for (int i = 0; i < NB; i++)
                if (!w_be_n[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rw    <= 1'b1;
            r_addr  <= '0;
            r_be_n  <= '1;
            r_wd    <= '0;
            r_rd    <= '0;
            r_rdy_n <= 1'b1;
            r_err_n <= 1'b1;
        end else begin
            r_rdy_n <= !w_go;
            r_err_n <= !(w_go && w_err);
            if (w_go && w_rw) r_rd <= w_oor ? '0 : r_mem[w_idx];
            if (w_req) begin
                r_rw    <= RW;
                r_addr  <= Addr;
                r_be_n  <= ByteEn_;
                r_wd    <= WrData;
                r_cnt   <= WS_M1;
                r_state <= (WAIT_STATES == 0) ? S_ACK : S_WAIT;
            end else if (r_state == S_WAIT) begin
                if (r_cnt == 4'd0) r_state <= S_ACK;
                else r_cnt <= r_cnt - 4'd1;
            end else if (r_state == S_ACK) begin
                r_state <= S_IDLE;
            end
        end
    end

    assign RdData = r_rd;
    assign Rdy_   = r_rdy_n;
    assign Err_   = r_err_n;
endmodule

// File: tb/tb_mem_slave.sv
// tb_mem_slave: directed checks of three mem_slave configurations
// (RAM 0 wait, RAM 3 wait, ROM 0 wait) sharing one bus.
module tb_mem_slave;
    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        cs_n [3];
    logic        as_n = 1'b1;
    logic        rw = 1'b1;
    logic [29:0] addr = '0;
    logic [3:0]  be_n = '1;
    logic [31:0] wd = '0;
    logic [31:0] rd [3];
    logic        rdy [3];
    logic        err [3];
    int          n_vec = 0;
    int          n_bad = 0;
    int          ws [3] = '{0, 3, 0};
    logic [31:0] v [4] = '{32'hA0000000, 32'h0B000001, 32'h00C00002, 32'h000D0003};

    always #5 clk = ~clk;

    mem_slave #(.WAIT_STATES(0), .WRITABLE(1)) u_w0 (
        .clk(clk), .reset_(reset_), .CS_(cs_n[0]), .As_(as_n), .RW(rw), .Addr(addr),
        .ByteEn_(be_n), .WrData(wd), .RdData(rd[0]), .Rdy_(rdy[0]), .Err_(err[0]));
    mem_slave #(.WAIT_STATES(3), .WRITABLE(1)) u_w3 (
        .clk(clk), .reset_(reset_), .CS_(cs_n[1]), .As_(as_n), .RW(rw), .Addr(addr),
        .ByteEn_(be_n), .WrData(wd), .RdData(rd[1]), .Rdy_(rdy[1]), .Err_(err[1]));
    mem_slave #(.WAIT_STATES(0), .WRITABLE(0)) u_ro (
        .clk(clk), .reset_(reset_), .CS_(cs_n[2]), .As_(as_n), .RW(rw), .Addr(addr),
        .ByteEn_(be_n), .WrData(wd), .RdData(rd[2]), .Rdy_(rdy[2]), .Err_(err[2]));

    // One access on instance k; returns cycles from strobe edge to Rdy_ low.
    task automatic do_access(input int k, input logic r, input logic [29:0] a,
                             input logic [3:0] b, input logic [31:0] d,
                             output int lat, output logic [31:0] q, output logic e);
        @(negedge clk);
        cs_n[k] = 1'b0; as_n = 1'b0; rw = r; addr = a; be_n = b; wd = d;
        @(negedge clk);
        as_n = 1'b1; cs_n = '{1'b1, 1'b1, 1'b1};
        lat = 0;
        while (rdy[k] !== 1'b0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        q = rd[k];
        e = err[k];
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        repeat (2) @(negedge clk);
        reset_ = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if ({rdy[k], err[k], rd[k]} !== {1'b1, 1'b1, 32'h0}) begin
                    n_bad++;
                    $display("FAIL reset idle inst%0d cyc%0d: rdy=%b err=%b rd=%h want 1 1 0", k, c, rdy[k], err[k], rd[k]);
                end
            end
        end
    endtask

    task automatic test_read_w0();
        int lat; logic [31:0] q; logic e;
        do_access(0, 1'b0, 30'd5, 4'b0000, 32'hDEADBEEF, lat, q, e);
        do_access(0, 1'b1, 30'd5, 4'b1111, 32'h0, lat, q, e);
        n_vec++;
        if ({lat, q, e} !== {32'd0, 32'hDEADBEEF, 1'b1}) begin
            n_bad++;
            $display("FAIL read_w0: lat=%0d rd=%h err=%b want 0 deadbeef 1", lat, q, e);
        end
    endtask

    task automatic test_wait_write();
        int lat; logic [31:0] q; logic e; int pulses; int first;
        do_access(1, 1'b0, 30'd10, 4'b0000, 32'hAABBCCDD, lat, q, e);
        do_access(1, 1'b0, 30'd10, 4'b1010, 32'h12345678, lat, q, e);
        n_vec++;
        if ({lat, e} !== {32'd3, 1'b1}) begin
            n_bad++;
            $display("FAIL wait_write: lat=%0d err=%b want 3 1", lat, e);
        end
        do_access(1, 1'b1, 30'd10, 4'b1111, 32'h0, lat, q, e);
        n_vec++;
        if ({lat, q, e} !== {32'd3, 32'hAA34CC78, 1'b1}) begin
            n_bad++;
            $display("FAIL wait_readback: lat=%0d rd=%h err=%b want 3 aa34cc78 1", lat, q, e);
        end
        // second strobe while in WAIT must be ignored
        @(negedge clk);
        cs_n[1] = 1'b0; as_n = 1'b0; rw = 1'b1; addr = 30'd10;
        @(negedge clk);
        addr = 30'd0;
        pulses = 0; first = -1;
        for (int c = 0; c < 10; c++) begin
            if (c == 1) begin as_n = 1'b1; cs_n[1] = 1'b1; end
            if (rdy[1] === 1'b0) begin
                pulses++;
                if (first < 0) first = c;
            end
            @(negedge clk);
        end
        n_vec++;
        if ({pulses, first} !== {32'd1, 32'd3}) begin
            n_bad++;
            $display("FAIL strobe_in_wait: pulses=%0d first=%0d want 1 3", pulses, first);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] q; logic e;
        for (int i = 0; i < 4; i++) do_access(0, 1'b0, 30'(i), 4'b0000, v[i], lat, q, e);
        @(negedge clk);
        cs_n[0] = 1'b0; as_n = 1'b0; rw = 1'b1; be_n = 4'b1111; addr = 30'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if ({rdy[0], err[0], rd[0]} !== {1'b0, 1'b1, v[i]}) begin
                n_bad++;
                $display("FAIL b2b[%0d]: rdy=%b err=%b rd=%h want 0 1 %h", i, rdy[0], err[0], rd[0], v[i]);
            end
            if (i < 3) addr = 30'(i + 1);
            else begin as_n = 1'b1; cs_n[0] = 1'b1; end
        end
        @(negedge clk);
        n_vec++;
        if (rdy[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_end: rdy=%b want 1", rdy[0]);
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] q; logic e;
        do_access(0, 1'b1, 30'h800, 4'b1111, 32'h0, lat, q, e);
        n_vec++;
        if ({lat, q, e} !== {32'd0, 32'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL oor_read: lat=%0d rd=%h err=%b want 0 0 0", lat, q, e);
        end
        do_access(0, 1'b0, 30'h800, 4'b0000, 32'hFFFFFFFF, lat, q, e);
        n_vec++;
        if ({lat, e} !== {32'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL oor_write: lat=%0d err=%b want 0 0", lat, e);
        end
        do_access(0, 1'b1, 30'd0, 4'b1111, 32'h0, lat, q, e);
        n_vec++;
        if ({q, e} !== {v[0], 1'b1}) begin
            n_bad++;
            $display("FAIL oor_mem0: rd=%h err=%b want %h 1", q, e, v[0]);
        end
        do_access(0, 1'b0, 30'd1, 4'b1111, 32'hFFFFFFFF, lat, q, e);
        n_vec++;
        if ({lat, e} !== {32'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL noop_write: lat=%0d err=%b want 0 1", lat, e);
        end
        do_access(0, 1'b1, 30'd1, 4'b1111, 32'h0, lat, q, e);
        n_vec++;
        if (q !== v[1]) begin
            n_bad++;
            $display("FAIL noop_readback: rd=%h want %h", q, v[1]);
        end
    endtask

    task automatic test_rom();
        int lat; logic [31:0] q; logic e;
        do_access(2, 1'b0, 30'd5, 4'b0000, 32'hFFFFFFFF, lat, q, e);
        n_vec++;
        if ({lat, e} !== {32'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL rom_write: lat=%0d err=%b want 0 0", lat, e);
        end
        do_access(2, 1'b1, 30'd5, 4'b1111, 32'h0, lat, q, e);
        n_vec++;
        if ({lat, q, e} !== {32'd0, 32'hDEADBEEF, 1'b1}) begin
            n_bad++;
            $display("FAIL rom_read: lat=%0d rd=%h err=%b want 0 deadbeef 1", lat, q, e);
        end
    endtask

    task automatic test_reset_mid_wait();
        int lat; logic [31:0] q; logic e; int pulses;
        @(negedge clk);
        cs_n[1] = 1'b0; as_n = 1'b0; rw = 1'b0; addr = 30'd10; be_n = 4'b0000; wd = 32'h0;
        @(negedge clk);
        as_n = 1'b1; cs_n[1] = 1'b1;
        @(negedge clk);
        reset_ = 1'b0;
        pulses = 0;
        repeat (2) begin @(negedge clk); if (rdy[1] === 1'b0) pulses++; end
        reset_ = 1'b1;
        repeat (6) begin @(negedge clk); if (rdy[1] === 1'b0) pulses++; end
        n_vec++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_wait_rdy: pulses=%0d want 0", pulses);
        end
        do_access(1, 1'b1, 30'd10, 4'b1111, 32'h0, lat, q, e);
        n_vec++;
        if ({lat, q, e} !== {32'd3, 32'hAA34CC78, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_mid_wait_mem: lat=%0d rd=%h err=%b want 3 aa34cc78 1", lat, q, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        cs_n = '{1'b1, 1'b1, 1'b1};
        u_ro.r_mem[5] = 32'hDEADBEEF;
        test_reset();
        test_read_w0();
        test_wait_write();
        test_back_to_back();
        test_out_of_range();
        test_rom();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
